interrupt_controller: RTL

- Collects device interrupt lines, latches them as pending, picks the highest-priority enabled source, and drives the CPU-side interrupt request (inta) and device number (idn) into the system register file.
- Consumes that file's qualified acknowledge (intaSig) and the return-from-interrupt strobe (isReti) to sequence one interrupt at a time.
- Sits between the I/O devices and the pipeline's system register file.

---
 rtl/interrupt_controller_pkg.sv | 29 ++
 rtl/irq_edge_sync.sv | 33 +++
 rtl/interrupt_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, index width
// helper and the fixed lowest-index-wins priority encoder.
package interrupt_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

   localparam int MAX_SRC   = 16;
   localparam int MAX_IDX_W = 4;

   // Bits needed to encode a source index; never less than one.
   function automatic int idx_width(input int num_src);
      return (num_src <= 2) ? 1 : $clog2(num_src);
   endfunction

   // Lowest set bit wins; scanning downward lets the lowest index overwrite last.
   function automatic logic [MAX_IDX_W-1:0] prio_encode(input logic [MAX_SRC-1:0] req);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = MAX_SRC - 1; i >= 0; i--) begin
         if (req[i]) idx = MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt line: multi-flop synchronizer followed by a rising-edge
// detector that emits a single-cycle pulse.
module irq_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic irq_in,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // NOTE: history resets to 0, so a line already high at reset release counts as a new edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/interrupt_controller.sv
// Latches device interrupt edges as pending, selects the lowest-index enabled
// source and sequences one request/acknowledge/return cycle at a time.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int DBITS       = 32,
   parameter int NUM_SRC     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irqIn,
   input  logic [NUM_SRC-1:0] irqMask,
   input  logic               intaAck,
   input  logic               isReti,
   output logic               inta,
   output logic [DBITS-1:0]   idn,
   output logic [NUM_SRC-1:0] pending,
   output logic               busy
);

   localparam int IDX_W = idx_width(NUM_SRC);

   logic [NUM_SRC-1:0] edge_vec;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clear_vec;
   logic [IDX_W-1:0]   winner;

   irq_state_e         state_q, state_d;
   logic               inta_q, inta_d;
   logic               busy_q, busy_d;
   logic [IDX_W-1:0]   idn_q, idn_d;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      irq_edge_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk        (clk),
         .reset      (reset),
         .irq_in     (irqIn[g]),
         .edge_pulse (edge_vec[g])
      );
   end

   // Masked sources keep latching pending; the mask only gates selection.
   assign eligible = pending_q & irqMask;
   assign winner   = IDX_W'(prio_encode(MAX_SRC'(eligible)));

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      inta_d    = inta_q;
      busy_d    = busy_q;
      idn_d     = idn_q;
      clear_vec = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               state_d = ST_REQ;
               inta_d  = 1'b1;
               busy_d  = 1'b1;
               idn_d   = winner;
            end
         end
         ST_REQ: begin
            // idn is frozen here; only the acknowledge moves us on.
            if (intaAck) begin
               state_d = ST_SERVICE;
               inta_d  = 1'b0;
               for (int i = 0; i < NUM_SRC; i++) begin
                  clear_vec[i] = (IDX_W'(i) == idn_q);
               end
            end
         end
         ST_SERVICE: begin
            if (isReti) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            inta_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      // A fresh edge in the clearing cycle keeps the bit set.
      pending_d = (pending_q & ~clear_vec) | edge_vec;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         inta_q  <= 1'b0;
         busy_q  <= 1'b0;
         idn_q   <= '0;
      end else begin
         state_q <= state_d;
         inta_q  <= inta_d;
         busy_q  <= busy_d;
         idn_q   <= idn_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   assign inta    = inta_q;
   assign busy    = busy_q;
   assign pending = pending_q;
   assign idn     = DBITS'(idn_q);

endmodule
